// File: rtl/ks_adder_pipe.sv
// ks_adder_pipe: pipelined Kogge-Stone adder with carry-in, signed-overflow flag
// and a valid/ready stream interface with a global stall.
// Optional build macro KSA_SUB_EN adds a 'sub' input that turns the stage into a - b.
// The prefix vector is shifted up one position so that bit 0 carries cin as its
// generate: prefix G at position i is then the carry into sum bit i.
module ks_adder_pipe #(
    parameter int unsigned WIDTH     = 16,
    parameter int unsigned REG_EVERY = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
`ifdef KSA_SUB_EN
    input  logic             sub,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int unsigned LEVELS  = $clog2(WIDTH);
    localparam int unsigned NGROUPS = (LEVELS + REG_EVERY - 1) / REG_EVERY;

    logic en;
    assign en       = !out_valid | out_ready;
    assign in_ready = en;

    logic [WIDTH-1:0] b_eff, p_raw, g_raw, pw, gw;
    logic             cin_eff;

    // Operand conditioning and per-bit propagate/generate, shifted for the cin slot
    always_comb begin
`ifdef KSA_SUB_EN
        b_eff   = sub ? ~b : b;
        cin_eff = sub ? 1'b1 : cin;
`else
        b_eff   = b;
        cin_eff = cin;
`endif
        p_raw = a ^ b_eff;
        g_raw = a & b_eff;
        pw    = {p_raw[WIDTH-2:0], 1'b0};
        gw    = {g_raw[WIDTH-2:0], cin_eff};
    end

    logic [WIDTH-1:0] s0_p, s0_g, s0_rp;
    logic             s0_gm, s0_v;

    // Stage 0 register bank: shifted P/G, raw p for the sum XOR, MSB generate, valid
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s0_p  <= '0;
            s0_g  <= '0;
            s0_rp <= '0;
            s0_gm <= 1'b0;
            s0_v  <= 1'b0;
        end else if (en) begin
            s0_p  <= pw;
            s0_g  <= gw;
            s0_rp <= p_raw;
            s0_gm <= g_raw[WIDTH-1];
            s0_v  <= in_valid;
        end
    end

    // Prefix levels; a level starting a new group reads the previous group's bank
    for (genvar k = 0; k < LEVELS; k++) begin : g_lvl
        localparam int SPAN = 1 << k;
        logic [WIDTH-1:0] lp, lg, po, go;
        if (k == 0) begin : g_src
            assign lp = s0_p;
            assign lg = s0_g;
        end else if (k % REG_EVERY == 0) begin : g_src
            assign lp = g_bank[k/REG_EVERY-1].p_q;
            assign lg = g_bank[k/REG_EVERY-1].g_q;
        end else begin : g_src
            assign lp = g_lvl[k-1].po;
            assign lg = g_lvl[k-1].go;
        end
        for (genvar i = 0; i < WIDTH; i++) begin : g_bit
            if (i < SPAN) begin : g_pass
                assign po[i] = lp[i];
                assign go[i] = lg[i];
            end else begin : g_comb
                assign po[i] = lp[i] & lp[i-SPAN];
                assign go[i] = lg[i] | (lp[i] & lg[i-SPAN]);
            end
        end
    end

    // Intermediate group banks; the final group's bank is the output register
    for (genvar gi = 0; gi < NGROUPS - 1; gi++) begin : g_bank
        logic [WIDTH-1:0] p_q, g_q, rp_q;
        logic             gm_q, v_q;
        logic [WIDTH-1:0] rp_in;
        logic             gm_in, v_in;
        if (gi == 0) begin : g_src
            assign rp_in = s0_rp;
            assign gm_in = s0_gm;
            assign v_in  = s0_v;
        end else begin : g_src
            assign rp_in = g_bank[gi-1].rp_q;
            assign gm_in = g_bank[gi-1].gm_q;
            assign v_in  = g_bank[gi-1].v_q;
        end

        // Group bank register, stalls with the rest of the pipe
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                p_q  <= '0;
                g_q  <= '0;
                rp_q <= '0;
                gm_q <= 1'b0;
                v_q  <= 1'b0;
            end else if (en) begin
                p_q  <= g_lvl[(gi+1)*REG_EVERY-1].po;
                g_q  <= g_lvl[(gi+1)*REG_EVERY-1].go;
                rp_q <= rp_in;
                gm_q <= gm_in;
                v_q  <= v_in;
            end
        end
    end

    logic [WIDTH-1:0] fin_rp;
    logic             fin_gm, fin_v;

    if (NGROUPS == 1) begin : g_fin
        assign fin_rp = s0_rp;
        assign fin_gm = s0_gm;
        assign fin_v  = s0_v;
    end else begin : g_fin
        assign fin_rp = g_bank[NGROUPS-2].rp_q;
        assign fin_gm = g_bank[NGROUPS-2].gm_q;
        assign fin_v  = g_bank[NGROUPS-2].v_q;
    end

    // Final group propagate is not needed once every carry is resolved
    logic unused_p;
    assign unused_p = ^g_lvl[LEVELS-1].po;

    logic [WIDTH-1:0] carry, sum_d;
    logic             cout_d, ovf_d;

    // Sum XOR, carry out and overflow from the resolved carries
    always_comb begin
        carry  = g_lvl[LEVELS-1].go;
        sum_d  = fin_rp ^ carry;
        cout_d = fin_gm | (fin_rp[WIDTH-1] & carry[WIDTH-1]);
        ovf_d  = carry[WIDTH-1] ^ cout_d;
    end

    // Output register bank; holds while the consumer back-pressures
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            sum       <= '0;
            cout      <= 1'b0;
            ovf       <= 1'b0;
        end else if (en) begin
            out_valid <= fin_v;
            sum       <= sum_d;
            cout      <= cout_d;
            ovf       <= ovf_d;
        end
    end

endmodule

// File: tb/tb_ks_adder_pipe.sv
// Scoreboard bench for ks_adder_pipe: the driver queues expected results on each
// accepted operand, and a monitor pops and compares whenever a result is taken.
module tb_ks_adder_pipe;

    parameter int unsigned WIDTH     = 16;
    parameter int unsigned REG_EVERY = 1;
    localparam int unsigned LEVELS = $clog2(WIDTH);
    localparam int unsigned LAT    = 1 + (LEVELS + REG_EVERY - 1) / REG_EVERY;

    typedef struct packed {
        logic [WIDTH-1:0] sum;
        logic             cout;
        logic             ovf;
    } res_t;

    logic             clk, rst, in_valid, in_ready, cin, sub, out_valid, out_ready, cout, ovf;
    logic [WIDTH-1:0] a, b, sum;

    ks_adder_pipe #(.WIDTH(WIDTH), .REG_EVERY(REG_EVERY)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
`ifdef KSA_SUB_EN
        .sub       (sub),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .ovf       (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    res_t             exp_q[$];
    int               n_vec  = 0;
    int               n_fail = 0;
    logic [WIDTH-1:0] va[12], vb[12];
    logic             vc[12];
    res_t             ve[12];

    function automatic res_t mk(logic [WIDTH-1:0] s, logic c, logic o);
        res_t r;
        r.sum  = s;
        r.cout = c;
        r.ovf  = o;
        return r;
    endfunction

    // Arithmetic reference: widened add, overflow from operand and result signs
    function automatic res_t model(logic [WIDTH-1:0] x, logic [WIDTH-1:0] y, logic c);
        logic [WIDTH:0] s;
        s = {1'b0, x} + {1'b0, y} + {{WIDTH{1'b0}}, c};
        return mk(s[WIDTH-1:0], s[WIDTH], (x[WIDTH-1] == y[WIDTH-1]) && (s[WIDTH-1] != x[WIDTH-1]));
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_vec++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    task automatic set_vec(input int i, input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                           input logic c, input logic [WIDTH-1:0] s, input logic co,
                           input logic o);
        va[i] = x;
        vb[i] = y;
        vc[i] = c;
        ve[i] = mk(s, co, o);
    endtask

    // Present one operand until accepted, then queue its expected result
    task automatic send(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y, input logic c,
                        input logic s, input res_t e);
        bit acc;
        int waits;
        a = x;
        b = y;
        cin = c;
        sub = s;
        in_valid = 1'b1;
        acc = 1'b0;
        waits = 0;
        while (!acc && waits < 50) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            waits++;
        end
        if (acc) exp_q.push_back(e);
        else begin
            n_vec++;
            n_fail++;
            $display("FAIL accept_timeout: in_ready stayed 0 for %0d cycles, expected 1", waits);
        end
        #1;
    endtask

    task automatic drain();
        int waits;
        waits = 0;
        while (exp_q.size() != 0 && waits < 200) begin
            @(posedge clk);
            waits++;
        end
        #1;
        check("drain_pending", exp_q.size(), 0);
    endtask

    // Monitor: compare every result the consumer takes against the queue head
    always @(negedge clk) begin : mon
        res_t e;
        if (!rst && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                n_vec++;
                n_fail++;
                $display("FAIL unexpected_result: got sum=%0h, expected no result", sum);
            end else begin
                e = exp_q.pop_front();
                check("result", {sum, cout, ovf}, e);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        int seen;
        logic [WIDTH-1:0] held;

        set_vec(0,  16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0);
        set_vec(1,  16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1);
        set_vec(2,  16'h1234, 16'h4321, 1'b1, 16'h5556, 1'b0, 1'b0);
        set_vec(3,  16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1);
        set_vec(4,  16'h0000, 16'h0000, 1'b1, 16'h0001, 1'b0, 1'b0);
        set_vec(5,  16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, 1'b0);
        set_vec(6,  16'hAAAA, 16'h5555, 1'b0, 16'hFFFF, 1'b0, 1'b0);
        set_vec(7,  16'hAAAA, 16'h5555, 1'b1, 16'h0000, 1'b1, 1'b0);
        set_vec(8,  16'h4000, 16'h4000, 1'b0, 16'h8000, 1'b0, 1'b1);
        set_vec(9,  16'h8001, 16'hFFFF, 1'b0, 16'h8000, 1'b1, 1'b0);
        set_vec(10, 16'h1234, 16'hEDCB, 1'b0, 16'hFFFF, 1'b0, 1'b0);
        set_vec(11, 16'h00FF, 16'h0F01, 1'b0, 16'h1000, 1'b0, 1'b0);

        rst = 1'b1;
        in_valid = 1'b0;
        a = '0;
        b = '0;
        cin = 1'b0;
        sub = 1'b0;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // Reset state
        @(negedge clk);
        check("rst_out_valid", out_valid, 0);
        check("rst_sum", sum, 0);
        check("rst_cout_ovf", {cout, ovf}, 0);
        check("rst_in_ready", in_ready, 1);
        @(posedge clk);
        #1;

        // Single operand into an empty pipe: latency
        send(va[0], vb[0], vc[0], 1'b0, ve[0]);
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check("latency", lat, LAT);
        drain();

        // Remaining directed vectors back to back
        for (int i = 1; i < 12; i++) send(va[i], vb[i], vc[i], 1'b0, ve[i]);
        in_valid = 1'b0;
        drain();

        // Walking-one patterns against the arithmetic reference
        for (int i = 0; i < WIDTH; i++) begin
            send(WIDTH'(1) << i, ~(WIDTH'(1) << i), i[0], 1'b0,
                 model(WIDTH'(1) << i, ~(WIDTH'(1) << i), i[0]));
            send(WIDTH'(1) << i, WIDTH'(1) << i, ~i[0], 1'b0,
                 model(WIDTH'(1) << i, WIDTH'(1) << i, ~i[0]));
        end
        in_valid = 1'b0;
        drain();

        // Eight-operand stream with the consumer stalled on cycles 6..8
        fork
            begin
                for (int j = 0; j < 8; j++) send(va[j], vb[j], vc[j], 1'b0, ve[j]);
                in_valid = 1'b0;
            end
            begin
                for (int c = 1; c <= 10; c++) begin
                    out_ready = (c >= 6 && c <= 8) ? 1'b0 : 1'b1;
                    @(negedge clk);
                    check("stall_in_ready", in_ready, (c >= 6 && c <= 8) ? 0 : 1);
                    if (c == 6) held = sum;
                    if (c >= 6 && c <= 8) check("stall_out_valid", out_valid, 1);
                    if (c == 7 || c == 8) check("stall_hold_sum", sum, held);
                    @(posedge clk);
                    #1;
                end
                out_ready = 1'b1;
            end
        join
        drain();

        // Reset with operations in flight
        send(va[2], vb[2], vc[2], 1'b0, ve[2]);
        send(va[6], vb[6], vc[6], 1'b0, ve[6]);
        send(va[8], vb[8], vc[8], 1'b0, ve[8]);
        in_valid = 1'b0;
        seen = 0;
        while (!out_valid && seen < 20) begin
            @(posedge clk);
            #1;
            seen++;
        end
        check("pre_rst_out_valid", out_valid, 1);
        exp_q.delete();
        rst = 1'b1;
        #1;
        check("async_rst_out_valid", out_valid, 0);
        check("async_rst_sum", sum, 0);
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b0;
        seen = 0;
        repeat (10) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        check("no_result_after_rst", seen, 0);
        @(posedge clk);
        #1;

`ifdef KSA_SUB_EN
        // Subtract mode: cin is ignored
        send(16'h0005, 16'h0007, 1'b0, 1'b1, mk(16'hFFFE, 1'b0, 1'b0));
        send(16'h8000, 16'h0001, 1'b0, 1'b1, mk(16'h7FFF, 1'b1, 1'b1));
        send(16'h0005, 16'h0007, 1'b1, 1'b1, mk(16'hFFFE, 1'b0, 1'b0));
        send(16'h0009, 16'h0003, 1'b0, 1'b1, mk(16'h0006, 1'b1, 1'b0));
        in_valid = 1'b0;
        sub = 1'b0;
        drain();
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule

// File: doc/ks_adder_pipe.md
# ks_adder_pipe

Parametrised, pipelined Kogge-Stone adder built on a per-bit propagate/generate front end. It generalises the fixed 16-bit PG stage to any power-of-two width and adds a configurable register cadence through the prefix tree. It also adds carry-in, signed-overflow flagging, and a valid/ready stream interface with full back-pressure. It sits in the datapath wherever a registered, throughput-one adder is needed.

## Interface
- `WIDTH`, 16: operand width; power of two, 4..64.
- `REG_EVERY`, 1: prefix levels between pipeline registers; range 1..clog2(WIDTH).
- `clk`, in, 1: clock; all state on rising edge.
- `rst`, in, 1: reset, asynchronous, active-high.
- `in_valid`, in, 1: operands valid.
- `in_ready`, out, 1: stage accepts operands this cycle.
- `a`, in, WIDTH: operand A.
- `b`, in, WIDTH: operand B.
- `cin`, in, 1: carry in.
- `out_valid`, out, 1: result valid.
- `out_ready`, in, 1: consumer accepts result.
- `sum`, out, WIDTH: a + b + cin, modulo 2^WIDTH.
- `cout`, out, 1: carry out of bit WIDTH-1.
- `ovf`, out, 1: two's-complement overflow, computed as carry into MSB XOR cout.

## Operation
- Stage 0 registers per-bit pair {p, g}: p = a^b, g = a&b. It also registers cin, folded as bit -1 generate, and raw p for the sum XOR.
- Prefix tree: LEVELS = clog2(WIDTH) Kogge-Stone levels; level k combines span 2^k: G = Gh | (Ph & Gl), P = Ph & Pl. Positions with i < 2^k pass through unchanged.
- Levels are grouped REG_EVERY per group; the last group may be shorter. Each group ends in a register bank holding {P, G, raw p, valid}.
- Sum XOR (sum[i] = p[i] ^ carry[i-1]), cout, and ovf are computed in the final group's cycle and registered in that group's bank. All outputs are registered.
- Global stall: en = !out_valid | out_ready. Every stage register, including valids, loads only when en. in_ready = en.
- A transfer occurs on in_valid & in_ready. Stage 0 valid loads in_valid & en.
- Bubbles are not collapsed. Order is strictly preserved; no result is dropped or duplicated.
- sum/cout/ovf hold stable while out_valid & !out_ready.

## Timing
- LATENCY = 1 + ceil(LEVELS / REG_EVERY) cycles from accepted input to out_valid, with no stall. WIDTH=16 gives: REG_EVERY=1 → 5, REG_EVERY=2 → 3, REG_EVERY=4 → 2.
- Throughput is one result per cycle while out_ready = 1.
- Reset, asserted at any time: all valid bits go 0 immediately, and every data register, sum, cout, and ovf go 0. in_ready is 1 after reset. In-flight operations are discarded; none emerge after deassertion.
- When out_ready falls with the pipeline full, in_ready falls in the same cycle, combinationally. No input is accepted until the head result is taken.
- Simultaneous out_ready=1 and in_valid=1 with a full pipe: the head result leaves and the new operand enters in the same edge.

## Configuration
- `KSA_SUB_EN` defined: adds input port `sub` (in, 1). When sub=1, stage 0 uses ~b and forces effective carry-in to 1, giving a - b; cin is ignored. cout is then the no-borrow flag, and ovf is signed subtraction overflow. sub is sampled with the operands and travels with them.
- Not defined: no `sub` port; add only.

## Test plan
- WIDTH=16, REG_EVERY=1: a=0xFFFF, b=0x0001, cin=0 → sum=0x0000, cout=1, ovf=0, out_valid exactly 5 cycles after acceptance.
- a=0x7FFF, b=0x0001, cin=0 → sum=0x8000, cout=0, ovf=1. Then a=0x1234, b=0x4321, cin=1 → sum=0x5556, cout=0, ovf=0.
- Stream 8 back-to-back operands with out_ready low on cycles 6-8 → in_ready low on exactly those cycles, outputs held stable, all 8 results in order, none lost.
- Assert rst while 3 operations are in flight → out_valid=0 and sum=0 immediately. No result appears within 10 cycles after deassert without new input.
- Sweep REG_EVERY ∈ {1,2,4} on 10k random operands against a reference model → zero mismatches; latencies 5/3/2.
- KSA_SUB_EN, sub=1: a=0x0005, b=0x0007 → sum=0xFFFE, cout=0, ovf=0. a=0x8000, b=0x0001 → sum=0x7FFF, cout=1, ovf=1.
